// File: rtl/audio_capture_pkg.sv
// rtl/audio_capture_pkg.sv - shared FSM state, address default and sample widths for the audio capture path
package audio_capture_pkg;

  localparam int ADDR_W     = 24;
  localparam int SAMPLE_W   = 12;
  localparam int WORD_W     = 16;
  localparam int FRAME_BITS = 16;

  localparam logic [ADDR_W-1:0] START_ADDR_DEFAULT = 24'h010000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    CONVERT,
    STORE,
    FINISH
  } state_t;

  // Samples are stored left-justified so playback treats them as 16-bit words.
  function automatic logic [WORD_W-1:0] sample_to_word(input logic [SAMPLE_W-1:0] sample);
    return {sample, {(WORD_W-SAMPLE_W){1'b0}}};
  endfunction

endpackage

// File: rtl/audio_capture_adc_spi_rx.sv
// rtl/audio_capture_adc_spi_rx.sv - ADC serial frame receiver: SCLK generation, 16-bit shift, frame-done strobe
module adc_spi_rx
  import audio_capture_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                sclk,
  output logic                cs_n,
  input  logic                sdata,
  output logic [SAMPLE_W-1:0] sample,
  output logic                frame_done
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  logic [HW-1:0] half_cnt;
  logic [BW-1:0] bit_cnt;

  // All 16 frame bits pass through a 12-bit shifter, so the four leading bits fall off the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk       <= 1'b1;
      cs_n       <= 1'b1;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      sample     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_n) begin
        if (start) begin
          cs_n     <= 1'b0;
          sclk     <= 1'b1;
          half_cnt <= '0;
          bit_cnt  <= '0;
        end
      end else if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        if (sclk) begin
          sclk <= 1'b0;
        end else begin
          sclk    <= 1'b1;
          sample  <= {sample[SAMPLE_W-2:0], sdata};
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == BIT_LAST) begin
            cs_n       <= 1'b1;
            frame_done <= 1'b1;
          end
        end
      end else begin
        half_cnt <= half_cnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/audio_capture.sv
// rtl/audio_capture.sv - ADC-to-memory audio recorder; AUDIO_CAPTURE_OVERRUN_CNT_EN enables the dropped-sample counter
module audio_capture
  import audio_capture_pkg::*;
#(
  parameter int          SAMPLE_DIV = 8192,
  parameter int          SCLK_HALF  = 2,
  parameter logic [23:0] START_ADDR = START_ADDR_DEFAULT,
  parameter logic [23:0] END_ADDR   = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        record,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  input  logic        adc_sdata,
  output logic [23:0] addr,
  output logic [15:0] audio_data_to_mem,
  output logic        audio_we,
  input  logic        mem_ack,
  output logic [23:0] stop_position,
  output logic        done,
  output logic [7:0]  overrun_cnt
);

  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [SW-1:0] SDIV_LAST = SW'(SAMPLE_DIV - 1);

  state_t              state;
  state_t              state_next;
  logic [SW-1:0]       sdiv_cnt;
  logic                running;
  logic                tick;
  logic                spi_start;
  logic                frame_done;
  logic [SAMPLE_W-1:0] spi_sample;

  adc_spi_rx #(
    .SCLK_HALF(SCLK_HALF)
  ) u_spi (
    .clk       (clk),
    .rst       (rst),
    .start     (spi_start),
    .sclk      (adc_sclk),
    .cs_n      (adc_cs_n),
    .sdata     (adc_sdata),
    .sample    (spi_sample),
    .frame_done(frame_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (record && !done) state_next = WAIT_TICK;
      WAIT_TICK: begin
        if (!record)   state_next = FINISH;
        else if (tick) state_next = CONVERT;
      end
      CONVERT:   if (frame_done) state_next = STORE;
      STORE:     if (mem_ack) state_next = (addr == END_ADDR || !record) ? FINISH : WAIT_TICK;
      FINISH:    if (!record) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    running   = (state != IDLE) && (state != FINISH);
    tick      = running && (sdiv_cnt == SDIV_LAST);
    spi_start = (state == WAIT_TICK) && record && tick;
    audio_we  = (state == STORE);
  end

  // done mirrors FINISH, so leaving FINISH is what clears it for the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr              <= START_ADDR;
      stop_position     <= START_ADDR;
      audio_data_to_mem <= '0;
      done              <= 1'b0;
      sdiv_cnt          <= '0;
    end else begin
      done <= (state_next == FINISH);

      if (!running || sdiv_cnt == SDIV_LAST) sdiv_cnt <= '0;
      else                                   sdiv_cnt <= sdiv_cnt + SW'(1);

      if (state == IDLE && state_next == WAIT_TICK) addr <= START_ADDR;

      if (state == CONVERT && frame_done) audio_data_to_mem <= sample_to_word(spi_sample);

      if (state == STORE && mem_ack) begin
        stop_position <= addr;
        if (state_next == WAIT_TICK) addr <= addr + 24'd1;
      end
    end
  end

`ifdef AUDIO_CAPTURE_OVERRUN_CNT_EN
  logic [7:0] overrun_q;
  logic       busy;

  assign busy = (state == CONVERT) || (state == STORE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           overrun_q <= '0;
    else if (state == IDLE && state_next == WAIT_TICK) overrun_q <= '0;
    else if (tick && busy && overrun_q != 8'hFF)       overrun_q <= overrun_q + 8'd1;
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_audio_capture.sv
// tb/tb_audio_capture.sv - self-checking bench for audio_capture with ADC and memory models
`timescale 1ns/1ps
module tb_audio_capture;

  localparam int          SAMPLE_DIV = 200;
  localparam int          SCLK_HALF  = 2;
  localparam logic [23:0] START      = 24'h010000;
  localparam logic [23:0] LAST       = 24'h010003;
`ifdef AUDIO_CAPTURE_OVERRUN_CNT_EN
  localparam int EXP_OVR = 1;
`else
  localparam int EXP_OVR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        record;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic        adc_sdata = 1'b0;
  logic [23:0] addr;
  logic [15:0] audio_data_to_mem;
  logic        audio_we;
  logic        mem_ack = 1'b0;
  logic [23:0] stop_position;
  logic        done;
  logic [7:0]  overrun_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  audio_capture #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .SCLK_HALF (SCLK_HALF),
    .START_ADDR(START),
    .END_ADDR  (LAST)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .record           (record),
    .adc_sclk         (adc_sclk),
    .adc_cs_n         (adc_cs_n),
    .adc_sdata        (adc_sdata),
    .addr             (addr),
    .audio_data_to_mem(audio_data_to_mem),
    .audio_we         (audio_we),
    .mem_ack          (mem_ack),
    .stop_position    (stop_position),
    .done             (done),
    .overrun_cnt      (overrun_cnt)
  );

  // ADC: each chip-select frame returns the next word of words[], MSB first, changing on SCLK fall.
  logic [15:0] words [0:63];
  logic [15:0] cur_word;
  int          frame_idx = 0;
  int          bit_k = 0;

  always @(negedge adc_cs_n or negedge adc_sclk) begin
    if (adc_sclk) begin
      cur_word  = words[frame_idx % 64];
      frame_idx = frame_idx + 1;
      bit_k     = 0;
    end else if (!adc_cs_n && bit_k < 16) begin
      adc_sdata = cur_word[15 - bit_k];
      bit_k     = bit_k + 1;
    end
  end

  // Memory: acknowledges after ack_delay extra cycles of audio_we and logs each accepted write.
  typedef struct {
    logic [23:0] a;
    logic [15:0] d;
    int          hold;
    bit          stable;
  } wr_t;

  wr_t         wr_q[$];
  int          ack_delay;
  int          we_cycles = 0;
  logic [23:0] a0;
  logic [15:0] d0;
  bit          stab;

  always @(negedge clk) begin
    if (rst || !audio_we) begin
      mem_ack   = 1'b0;
      we_cycles = 0;
    end else begin
      if (we_cycles == 0) begin
        a0   = addr;
        d0   = audio_data_to_mem;
        stab = 1'b1;
      end else if (addr !== a0 || audio_data_to_mem !== d0) begin
        stab = 1'b0;
      end
      we_cycles = we_cycles + 1;
      if (we_cycles > ack_delay) begin
        mem_ack = 1'b1;
        wr_q.push_back('{a0, d0, we_cycles, stab});
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c = 0;
    while (wr_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("write_count", wr_q.size(), n);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_set", done, 1'b1);
  endtask

  // Write i of a capture lands at START+i holding the low 12 bits of frame i, left-justified.
  task automatic check_writes(input int wb, input int n, input int fb, input int hold_exp);
    for (int i = 0; i < n; i++) begin
      if (wb + i < wr_q.size()) begin
        check("wr_addr", wr_q[wb+i].a, START + 24'(i));
        check("wr_data", wr_q[wb+i].d, {words[(fb+i) % 64][11:0], 4'h0});
        check("wr_stable", wr_q[wb+i].stable, 1'b1);
        if (hold_exp > 0) check("wr_hold", wr_q[wb+i].hold, hold_exp);
      end
    end
  endtask

  task automatic fill_words(input int fb);
    for (int i = 0; i < 8; i++) words[(fb+i) % 64] = 16'($urandom);
  endtask

  task automatic go_idle();
    record = 1'b0;
    repeat (4) @(negedge clk);
    check("done_cleared", done, 1'b0);
  endtask

  int wb;
  int fb;
  int k;
  int c;

  initial begin
    for (int i = 0; i < 64; i++) words[i] = 16'h0;
    rst       = 1'b1;
    record    = 1'b0;
    ack_delay = 0;
    repeat (3) @(negedge clk);
    check("rst_addr", addr, START);
    check("rst_stop", stop_position, START);
    check("rst_data", audio_data_to_mem, 16'h0);
    check("rst_we", audio_we, 1'b0);
    check("rst_cs_n", adc_cs_n, 1'b1);
    check("rst_sclk", adc_sclk, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_ovr", overrun_cnt, 8'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Immediate ack, ADC returns 0xABC first
    wb = wr_q.size(); fb = frame_idx; fill_words(fb);
    words[fb % 64] = {4'($urandom), 12'hABC};
    ack_delay = 0;
    record = 1'b1;
    wait_writes(wb + 2, 4 * SAMPLE_DIV);
    record = 1'b0;
    wait_done(50);
    check("abc_word", wr_q[wb].d, 16'hABC0);
    check_writes(wb, 2, fb, 1);
    check("abc_stop", stop_position, START + 24'd1);
    check("abc_ovr", overrun_cnt, 8'h0);
    go_idle();

    // Ack three cycles late: one write held four cycles
    wb = wr_q.size(); fb = frame_idx; fill_words(fb);
    ack_delay = 3;
    record = 1'b1;
    wait_writes(wb + 2, 4 * SAMPLE_DIV);
    record = 1'b0;
    wait_done(50);
    check_writes(wb, 2, fb, 4);
    check("late_count", wr_q.size(), wb + 2);
    go_idle();

    // Ack withheld beyond one sample period: one sample dropped
    wb = wr_q.size(); fb = frame_idx; fill_words(fb);
    ack_delay = SAMPLE_DIV + 50;
    record = 1'b1;
    wait_writes(wb + 1, 4 * SAMPLE_DIV);
    ack_delay = 0;
    wait_writes(wb + 2, 4 * SAMPLE_DIV);
    record = 1'b0;
    wait_done(50);
    check_writes(wb, 2, fb, 0);
    check("ovr_count", overrun_cnt, 8'(EXP_OVR));
    check("ovr_frames", frame_idx - fb, 2);
    go_idle();

    // Record held to END_ADDR: four writes then done, no more writes
    wb = wr_q.size(); fb = frame_idx; fill_words(fb);
    ack_delay = $urandom_range(0, 5);
    record = 1'b1;
    wait_done(8 * SAMPLE_DIV);
    check("end_count", wr_q.size(), wb + 4);
    check_writes(wb, 4, fb, ack_delay + 1);
    check("end_stop", stop_position, LAST);
    repeat (3 * SAMPLE_DIV) @(negedge clk);
    check("end_no_extra", wr_q.size(), wb + 4);
    check("end_done_held", done, 1'b1);
    check("end_addr_max", addr, LAST);
    go_idle();

    // Record dropped while the third sample is converting
    wb = wr_q.size(); fb = frame_idx; fill_words(fb);
    ack_delay = 0;
    record = 1'b1;
    wait_writes(wb + 2, 4 * SAMPLE_DIV);
    c = 0;
    while (adc_cs_n && c < 2 * SAMPLE_DIV) begin
      @(negedge clk);
      c++;
    end
    check("third_convert", adc_cs_n, 1'b0);
    repeat (10) @(negedge clk);
    record = 1'b0;
    wait_done(200);
    check("drop_count", wr_q.size(), wb + 3);
    check_writes(wb, 3, fb, 1);
    check("drop_stop", stop_position, START + 24'd2);
    go_idle();

    // Reset while a write is pending
    wb = wr_q.size(); fb = frame_idx; fill_words(fb);
    ack_delay = 10000;
    record = 1'b1;
    c = 0;
    while (!audio_we && c < 2 * SAMPLE_DIV) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    check("store_we", audio_we, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("arst_we", audio_we, 1'b0);
    check("arst_cs_n", adc_cs_n, 1'b1);
    check("arst_addr", addr, START);
    check("arst_done", done, 1'b0);
    check("arst_no_write", wr_q.size(), wb);
    record = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Random captures of one to three samples
    for (int it = 0; it < 3; it++) begin
      wb = wr_q.size(); fb = frame_idx; fill_words(fb);
      k = $urandom_range(1, 3);
      ack_delay = $urandom_range(0, 8);
      record = 1'b1;
      wait_writes(wb + k, (k + 2) * SAMPLE_DIV);
      record = 1'b0;
      wait_done(50);
      check_writes(wb, k, fb, ack_delay + 1);
      check("rnd_stop", stop_position, START + 24'(k - 1));
      check("rnd_ovr", overrun_cnt, 8'h0);
      go_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
